// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch / exec / mem / commit over a shared memory bus.
// Optional bus-ack timeout with FAULT state is enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic [31:0] pc,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] dmem_rdata,
  output logic        reg_we,
  output logic        pc_en,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    COMMIT = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic [31:0] addr_lat_q, addr_lat_d;
  logic [31:0] wdata_lat_q, wdata_lat_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        inst_valid_q, inst_valid_d;
  logic        reg_we_q, reg_we_d;
  logic        pc_en_q, pc_en_d;

  logic [6:0]  opcode;
  logic        is_store;
  logic        is_mem;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  assign opcode   = inst_q[6:0];
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    dmem_rdata_d = dmem_rdata_q;
    addr_lat_d   = addr_lat_q;
    wdata_lat_d  = wdata_lat_q;
`ifdef SEQ_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE:   if (!halt) state_d = FETCH;
      FETCH:  if (bus_ack) begin
                inst_d  = bus_rdata;
                state_d = EXEC;
              end
      EXEC:   if (is_mem) begin
                addr_lat_d  = dmem_addr;
                wdata_lat_d = dmem_wdata;
                state_d     = MEM;
              end else begin
                state_d = COMMIT;
              end
      MEM:    if (bus_ack) begin
                if (!is_store) dmem_rdata_d = bus_rdata;
                state_d = COMMIT;
              end
      COMMIT: state_d = IDLE;
`ifdef SEQ_TIMEOUT_EN
      FAULT:  state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase

`ifdef SEQ_TIMEOUT_EN
    // Counter restarts on entry to a bus state; a wait that reaches the limit diverts to FAULT.
    if ((state_d != state_q) && (state_d inside {FETCH, MEM})) begin
      cnt_d = '0;
    end else if ((state_q inside {FETCH, MEM}) && !bus_ack) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == TIMEOUT_LIM) state_d = FAULT;
    end
    fault_d = (state_d == FAULT);
`endif

    // Outputs are registered from the next state so they line up with state_q.
    bus_req_d   = (state_d inside {FETCH, MEM});
    bus_we_d    = (state_d == MEM) && is_store;
    bus_addr_d  = '0;
    bus_wdata_d = '0;
    if (state_d == FETCH) begin
      bus_addr_d = (state_q == FETCH) ? bus_addr_q : pc;
    end else if (state_d == MEM) begin
      bus_addr_d  = addr_lat_d;
      bus_wdata_d = wdata_lat_d;
    end
    inst_valid_d = (state_d == EXEC);
    pc_en_d      = (state_d == COMMIT);
    reg_we_d     = (state_d == COMMIT) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      dmem_rdata_q <= '0;
      addr_lat_q   <= '0;
      wdata_lat_q  <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_valid_q <= 1'b0;
      reg_we_q     <= 1'b0;
      pc_en_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q        <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      dmem_rdata_q <= dmem_rdata_d;
      addr_lat_q   <= addr_lat_d;
      wdata_lat_q  <= wdata_lat_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_valid_q <= inst_valid_d;
      reg_we_q     <= reg_we_d;
      pc_en_q      <= pc_en_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign dmem_rdata = dmem_rdata_q;
  assign reg_we     = reg_we_q;
  assign pc_en      = pc_en_q;
`ifdef SEQ_TIMEOUT_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: addi, load, store, halt, reset-in-MEM, timeout.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, halt, bus_ack;
  logic [31:0] pc, dmem_addr, dmem_wdata, bus_rdata;
  logic        bus_req, bus_we, inst_valid, reg_we, pc_en, fault;
  logic [31:0] bus_addr, bus_wdata, inst, dmem_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .halt(halt), .pc(pc),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .inst(inst), .inst_valid(inst_valid), .dmem_rdata(dmem_rdata),
    .reg_we(reg_we), .pc_en(pc_en), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, bus_req, bus_we, inst_valid, reg_we, pc_en}, {27'd0, exp});
  endtask

  initial begin
    rst = 1'b1; halt = 1'b1; bus_ack = 1'b0; pc = 32'h0;
    dmem_addr = 32'h0; dmem_wdata = 32'h0; bus_rdata = 32'h0;
    tick(); tick();
    chk_strobes("reset_strobes", 5'b00000);
    chk("reset_inst", inst, 32'h0);
    chk("reset_dmem_rdata", dmem_rdata, 32'h0);
    chk("reset_bus_addr", bus_addr, 32'h0);
    chk("reset_fault", {31'd0, fault}, 32'h0);

    // addi, ack one cycle after request
    rst = 1'b0; halt = 1'b0; pc = 32'h100;
    tick();
    chk_strobes("addi_fetch1", 5'b10000);
    chk("addi_fetch_addr", bus_addr, 32'h100);
    tick();
    chk_strobes("addi_fetch2", 5'b10000);
    bus_ack = 1'b1; bus_rdata = 32'h00500093;
    tick();
    bus_ack = 1'b0;
    chk_strobes("addi_exec", 5'b00100);
    chk("addi_inst", inst, 32'h00500093);
    tick();
    chk_strobes("addi_commit", 5'b00011);
    chk("addi_commit_addr", bus_addr, 32'h0);
    tick();
    chk_strobes("addi_idle", 5'b00000);

    // load, same-cycle ack in FETCH, addr held while input changes
    pc = 32'h104;
    tick();
    chk("load_fetch_addr", bus_addr, 32'h104);
    bus_ack = 1'b1; bus_rdata = 32'h0000A103;
    tick();
    bus_ack = 1'b0;
    chk_strobes("load_exec", 5'b00100);
    chk("load_inst", inst, 32'h0000A103);
    dmem_addr = 32'h2000; dmem_wdata = 32'h55;
    tick();
    chk_strobes("load_mem1", 5'b10000);
    chk("load_mem_addr1", bus_addr, 32'h2000);
    dmem_addr = 32'hFFFF_0000;
    tick();
    chk_strobes("load_mem2", 5'b10000);
    chk("load_mem_addr2", bus_addr, 32'h2000);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ack = 1'b0; halt = 1'b1;
    chk_strobes("load_commit", 5'b00011);
    chk("load_rdata", dmem_rdata, 32'hDEADBEEF);
    tick();
    // ack in IDLE must be ignored
    bus_ack = 1'b1; bus_rdata = 32'h77;
    tick();
    bus_ack = 1'b0;
    chk_strobes("idle_halt", 5'b00000);
    chk("idle_ack_ignored", inst, 32'h0000A103);

    // store
    halt = 1'b0; pc = 32'h108;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h00112023;
    tick();
    bus_ack = 1'b0; dmem_addr = 32'h3000; dmem_wdata = 32'h12345678;
    tick();
    chk_strobes("store_mem", 5'b11000);
    chk("store_addr", bus_addr, 32'h3000);
    chk("store_wdata", bus_wdata, 32'h12345678);
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    tick();
    bus_ack = 1'b0;
    chk_strobes("store_commit", 5'b00001);
    chk("store_rdata_kept", dmem_rdata, 32'hDEADBEEF);
    chk("store_wdata_dropped", bus_wdata, 32'h0);
    tick();

    // halt raised during FETCH, branch acked on third FETCH cycle
    pc = 32'h10C;
    tick();
    halt = 1'b1;
    tick();
    chk_strobes("halt_fetch2", 5'b10000);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h00000063;
    tick();
    bus_ack = 1'b0;
    chk_strobes("halt_exec", 5'b00100);
    tick();
    chk_strobes("branch_commit", 5'b00001);
    tick(); tick(); tick();
    chk_strobes("halt_idle_held", 5'b00000);
    halt = 1'b0;
    tick();
    chk_strobes("unhalt_fetch", 5'b10000);

    // reset while in MEM with concurrent ack
    bus_ack = 1'b1; bus_rdata = 32'h0000A103;
    tick();
    bus_ack = 1'b0; dmem_addr = 32'h4000;
    tick();
    chk_strobes("rst_pre_mem", 5'b10000);
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    rst = 1'b0; bus_ack = 1'b0; halt = 1'b1;
    chk_strobes("rst_mem_strobes", 5'b00000);
    chk("rst_mem_rdata", dmem_rdata, 32'h0);
    chk("rst_mem_inst", inst, 32'h0);
    chk("rst_mem_addr", bus_addr, 32'h0);

`ifdef SEQ_TIMEOUT_EN
    halt = 1'b0; pc = 32'h200;
    tick();
    halt = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_wait_fault", {31'd0, fault}, 32'h0);
      chk_strobes("to_wait_req", 5'b10000);
    end
    tick();
    chk("to_fault", {31'd0, fault}, 32'h1);
    chk_strobes("to_fault_req", 5'b00000);
    bus_ack = 1'b1;
    tick(); tick();
    bus_ack = 1'b0;
    chk("to_fault_held", {31'd0, fault}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_fault_cleared", {31'd0, fault}, 32'h0);
`else
    // without the timeout a FETCH waits indefinitely and fault stays low
    halt = 1'b0; pc = 32'h200;
    tick();
    halt = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    chk("no_to_fault", {31'd0, fault}, 32'h0);
    chk_strobes("no_to_still_req", 5'b10000);
    chk("no_to_addr", bus_addr, 32'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, bus-ack wait limit in cycles (1..255, 8-bit counter).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 halt  input  1  hold sequencer in IDLE, no new fetch.
REQ-005 pc  input  32  address of next instruction.
REQ-006 dmem_addr  input  32  load/store address from ALU, valid in EXEC.
REQ-007 dmem_wdata  input  32  store data, valid in EXEC.
REQ-008 bus_req  output  1  shared memory bus request.
REQ-009 bus_we  output  1  bus write strobe (stores only).
REQ-010 bus_addr  output  32  bus address.
REQ-011 bus_wdata  output  32  bus write data.
REQ-012 bus_rdata  input  32  bus read data, valid with bus_ack.
REQ-013 bus_ack  input  1  bus completion, one-cycle pulse.
REQ-014 inst  output  32  latched instruction word to the decoder.
REQ-015 inst_valid  output  1  inst decodable this cycle (EXEC).
REQ-016 dmem_rdata  output  32  latched load data.
REQ-017 reg_we  output  1  register-file write enable, COMMIT only.
REQ-018 pc_en  output  1  advance PC, one-cycle pulse in COMMIT.
REQ-019 fault  output  1  bus timeout flag (SEQ_TIMEOUT_EN only; else tied 0).

Function
REQ-020 States SHALL be IDLE, FETCH, EXEC, MEM, COMMIT, FAULT; encoded 3 bits.
REQ-021 IDLE: halt=1 -> stay; halt=0 -> FETCH next cycle.
REQ-022 FETCH: bus_req=1, bus_we=0, bus_addr=pc; on bus_ack, inst <= bus_rdata, go EXEC.
REQ-023 EXEC: inst_valid=1 exactly one cycle; opcode inst[6:0] = 0000011 (load) or 0100011 (store) -> MEM; otherwise -> COMMIT.
REQ-024 MEM entry SHALL register dmem_addr and dmem_wdata from the EXEC cycle; bus_addr/bus_wdata driven from those registers while in MEM.
REQ-025 MEM: bus_req=1, bus_we=1 for store else 0; on bus_ack, load -> dmem_rdata <= bus_rdata; store leaves dmem_rdata unchanged; go COMMIT.
REQ-026 COMMIT: pc_en=1 one cycle; reg_we=1 unless opcode is 0100011 (store) or 1100011 (branch); then IDLE.
REQ-027 bus_req SHALL stay high continuously in FETCH/MEM until bus_ack; address/data stable throughout.
REQ-028 bus_ack outside FETCH/MEM SHALL be ignored; bus_ack same cycle as state entry SHALL be accepted.
REQ-029 halt asserted outside IDLE SHALL NOT abort the instruction; it takes effect at next IDLE.
REQ-030 Minimum latency: non-memory instruction 4 cycles (IDLE, FETCH with immediate ack, EXEC, COMMIT); load/store 5 cycles.
REQ-031 In all states not listed, bus_req, bus_we, inst_valid, pc_en, reg_we SHALL be 0; bus_addr/bus_wdata 0 when bus_req=0.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, inst=0, dmem_rdata=0, latched address/data=0, timeout counter=0, fault=0, all strobes 0, from next cycle.
REQ-033 Reset mid-transaction SHALL drop bus_req the next cycle; a concurrent bus_ack SHALL be discarded.
REQ-034 rst SHALL override halt and FAULT.

Configuration
REQ-035 Macro SEQ_TIMEOUT_EN defined: 8-bit counter clears on FETCH/MEM entry, increments each cycle without bus_ack; reaching TIMEOUT_CYCLES without ack -> FAULT; FAULT holds fault=1, bus_req=0, exits only on rst.
REQ-036 SEQ_TIMEOUT_EN undefined: no counter, FAULT unreachable, fault constant 0, FETCH/MEM wait indefinitely.

Verification
REQ-037 pc=0x100, ack 1 cycle after req, rdata=0x00500093 (addi) -> inst=0x00500093, inst_valid 1 cycle, reg_we=1 and pc_en=1 in COMMIT, no MEM state.
REQ-038 Load 0x0000A103, dmem_addr=0x2000, MEM ack rdata=0xDEADBEEF -> bus_addr=0x2000, bus_we=0, dmem_rdata=0xDEADBEEF, reg_we=1.
REQ-039 Store 0x00112023, dmem_wdata=0x12345678 -> MEM bus_we=1, bus_wdata=0x12345678, reg_we=0, pc_en=1.
REQ-040 halt=1 during FETCH with ack after 3 cycles -> instruction completes COMMIT, then IDLE held, bus_req=0 until halt=0.
REQ-041 rst pulsed while in MEM with bus_ack same cycle -> next cycle IDLE, bus_req=0, dmem_rdata=0.
REQ-042 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> fault=1 after 4 waiting cycles, bus_req=0, stays until rst.
